ascon_output_serializer: RTL and testbench

Bit-serial output stage for the Ascon core. It captures the parallel ciphertext and 128-bit tag when the core signals completion, then streams both LSB-first on two 1-bit lines, one bit per clock, under a valid strobe. It is the transmit end of the serial readout interface that the bench and host logic sample with a per-bit counter. The same instance type serves the decryption side: plaintext goes on the data line and the computed tag on the tag line.

---
 rtl/ascon_pkg.sv | 20 ++
 rtl/ascon_piso.sv | 37 +++
 rtl/ascon_output_serializer.sv | 116 +++++++++++
 tb/tb_ascon_output_serializer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared constants, state type and helpers for the Ascon serial output stage
package ascon_pkg;

  localparam int TAG_W = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_DONE
  } serStateT;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ascon_piso.sv
// rtl/ascon_piso.sv - W-bit parallel-load, LSB-first, zero-fill shift register
// The serial bit is registered from the register's next value so it lines up with the state that enables it.
module ascon_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         outEn,
  input  logic [W-1:0] parIn,
  output logic         serOut
);

  logic [W-1:0] shReg;
  logic [W-1:0] shNext;

  always_comb begin
    shNext = shReg;
    if (load) begin
      shNext = parIn;
    end else if (shift) begin
      shNext = shReg >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shReg  <= '0;
      serOut <= 1'b0;
    end else begin
      shReg  <= shNext;
      serOut <= outEn & shNext[0];
    end
  end

endmodule

// File: rtl/ascon_output_serializer.sv
// rtl/ascon_output_serializer.sv - captures data and tag, then streams both LSB-first under a valid strobe
module ascon_output_serializer #(
  parameter int Y     = 40,
  parameter int TAG_W = ascon_pkg::TAG_W,
  parameter int LEAD  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           loadxSI,
  input  logic [((Y > 0) ? Y : 1)-1:0]   data_parxDI,
  input  logic [TAG_W-1:0]               tag_parxDI,
  output logic                           data_serxSO,
  output logic                           tag_serxSO,
  output logic                           validxSO,
  output logic                           busyxSO,
  output logic                           donexSO
);
  import ascon_pkg::*;

  localparam int N  = (Y > TAG_W) ? Y : TAG_W;
  localparam int CW = clog2(N + 1);
  localparam int DW = (Y > 0) ? Y : 1;

  serStateT state, nextState;
  logic [CW-1:0] cnt, nextCnt;
  logic          load;
  logic          shiftEn;
  logic          outEn;
  logic [DW-1:0] dataLoad;

  // With no data payload the data register is loaded with zeros so its line stays low.
  assign dataLoad = (Y == 0) ? '0 : data_parxDI;

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (loadxSI) begin
          load = 1'b1;
          if (LEAD > 0) begin
            nextState = S_LEAD;
            nextCnt   = CW'(LEAD - 1);
          end else begin
            nextState = S_SHIFT;
            nextCnt   = CW'(N - 1);
          end
        end
      end
      S_LEAD: begin
        if (cnt == '0) begin
          nextState = S_SHIFT;
          nextCnt   = CW'(N - 1);
        end else begin
          nextCnt = cnt - 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt == '0) begin
          nextState = S_DONE;
        end else begin
          nextCnt = cnt - 1'b1;
        end
      end
      S_DONE: begin
        nextState = S_IDLE;
        nextCnt   = '0;
      end
      default: begin
        nextState = S_IDLE;
        nextCnt   = '0;
      end
    endcase
  end

  assign shiftEn = (state == S_SHIFT);
  assign outEn   = (nextState == S_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      validxSO <= 1'b0;
      busyxSO  <= 1'b0;
      donexSO  <= 1'b0;
    end else begin
      state    <= nextState;
      cnt      <= nextCnt;
      validxSO <= (nextState == S_SHIFT);
      busyxSO  <= (nextState != S_IDLE);
      donexSO  <= (nextState == S_DONE);
    end
  end

  ascon_piso #(.W(DW)) dataPiso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shiftEn),
    .outEn (outEn),
    .parIn (dataLoad),
    .serOut(data_serxSO)
  );

  ascon_piso #(.W(TAG_W)) tagPiso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shiftEn),
    .outEn (outEn),
    .parIn (tag_parxDI),
    .serOut(tag_serxSO)
  );

endmodule

// File: tb/tb_ascon_output_serializer.sv
// tb/tb_ascon_output_serializer.sv - self-checking bench for the Ascon serial output stage
module tb_ascon_output_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] loadV = '0;
  logic [255:0] dIn [4];
  logic [127:0] tIn [4];
  logic [3:0] dSer, tSer, vld, bsy, dn;

  int yOf [4]    = '{40, 0, 200, 40};
  int leadOf [4] = '{2, 2, 2, 0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ascon_output_serializer #(.Y(40), .TAG_W(128), .LEAD(2)) dutA (
    .clk(clk), .rst(rst), .loadxSI(loadV[0]), .data_parxDI(dIn[0][39:0]), .tag_parxDI(tIn[0]),
    .data_serxSO(dSer[0]), .tag_serxSO(tSer[0]), .validxSO(vld[0]), .busyxSO(bsy[0]), .donexSO(dn[0]));

  ascon_output_serializer #(.Y(0), .TAG_W(128), .LEAD(2)) dutZ (
    .clk(clk), .rst(rst), .loadxSI(loadV[1]), .data_parxDI(dIn[1][0:0]), .tag_parxDI(tIn[1]),
    .data_serxSO(dSer[1]), .tag_serxSO(tSer[1]), .validxSO(vld[1]), .busyxSO(bsy[1]), .donexSO(dn[1]));

  ascon_output_serializer #(.Y(200), .TAG_W(128), .LEAD(2)) dutW (
    .clk(clk), .rst(rst), .loadxSI(loadV[2]), .data_parxDI(dIn[2][199:0]), .tag_parxDI(tIn[2]),
    .data_serxSO(dSer[2]), .tag_serxSO(tSer[2]), .validxSO(vld[2]), .busyxSO(bsy[2]), .donexSO(dn[2]));

  ascon_output_serializer #(.Y(40), .TAG_W(128), .LEAD(0)) dutB (
    .clk(clk), .rst(rst), .loadxSI(loadV[3]), .data_parxDI(dIn[3][39:0]), .tag_parxDI(tIn[3]),
    .data_serxSO(dSer[3]), .tag_serxSO(tSer[3]), .validxSO(vld[3]), .busyxSO(bsy[3]), .donexSO(dn[3]));

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference: cycle c counted from the acceptance cycle; returns {valid, busy, done, dataBit, tagBit}.
  function automatic logic [4:0] expVec(input int k, input int c, input logic [255:0] d, input logic [127:0] t);
    int y, l, n, i;
    logic eV, eB, eDn, eD, eT;
    y = yOf[k];
    l = leadOf[k];
    n = (y > 128) ? y : 128;
    i = c - l - 1;
    eV  = (c >= l + 1) && (c <= l + n);
    eB  = (c >= 1) && (c <= l + n + 1);
    eDn = (c == l + n + 1);
    eD  = (eV && i < y) ? d[i] : 1'b0;
    eT  = (eV && i < 128) ? t[i] : 1'b0;
    return {eV, eB, eDn, eD, eT};
  endfunction

  function automatic logic [4:0] obsVec(input int k);
    return {vld[k], bsy[k], dn[k], dSer[k], tSer[k]};
  endfunction

  // Loads d/t into instance k and checks every cycle through the done cycle; returns at the done-cycle negedge.
  task automatic runBurst(input int k, input logic [255:0] d, input logic [127:0] t,
                          input bit keepLoad, input int hitBeat, input bit hitDone, input string name);
    int l, n;
    logic [4:0] got, exp;
    l = leadOf[k];
    n = (yOf[k] > 128) ? yOf[k] : 128;
    @(negedge clk);
    loadV[k] = 1'b1;
    dIn[k] = d;
    tIn[k] = t;
    for (int c = 1; c <= l + n + 1; c++) begin
      @(negedge clk);
      if (!keepLoad) loadV[k] = 1'b0;
      dIn[k] = rnd256();
      tIn[k] = rnd128();
      if ((hitBeat >= 0 && c == l + 1 + hitBeat) || (hitDone && c == l + n + 1)) loadV[k] = 1'b1;
      got = obsVec(k);
      exp = expVec(k, c, d, t);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d {valid,busy,done,data,tag} got %b expected %b", name, c, got, exp);
      end
    end
  endtask

  task automatic idleCheck(input int k, input int cycles, input string name);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      loadV[k] = 1'b0;
      checks++;
      if (obsVec(k) !== 5'b0) begin
        errors++;
        $display("FAIL %s idle cycle %0d outputs got %b expected 00000", name, c, obsVec(k));
      end
    end
  endtask

  task automatic test_reset();
    loadV = 4'hf;
    for (int k = 0; k < 4; k++) begin
      dIn[k] = rnd256();
      tIn[k] = rnd128();
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obsVec(k) !== 5'b0) begin
        errors++;
        $display("FAIL reset inst %0d outputs got %b expected 00000", k, obsVec(k));
      end
    end
    loadV = '0;
    rst = 1'b0;
    idleCheck(0, 2, "post_reset");
  endtask

  task automatic test_basic();
    logic [255:0] d;
    d = '0;
    d[39:0] = 40'h6173636f6e;
    runBurst(0, d, 128'h0123456789abcdeffedcba9876543210, 1'b0, -1, 1'b0, "basic_vector");
    runBurst(0, rnd256(), rnd128(), 1'b0, -1, 1'b0, "basic_rand_b2b");
    idleCheck(0, 3, "basic_idle");
  endtask

  task automatic test_load_while_busy();
    runBurst(0, rnd256(), rnd128(), 1'b0, 10, 1'b1, "busy_load");
    runBurst(0, rnd256(), rnd128(), 1'b0, 10, 1'b0, "busy_next_accept");
    idleCheck(0, 3, "busy_idle");
  endtask

  task automatic test_mid_reset();
    logic [255:0] d;
    logic [127:0] t;
    int l;
    logic [4:0] got, exp;
    d = rnd256();
    t = rnd128();
    l = leadOf[0];
    @(negedge clk);
    loadV[0] = 1'b1;
    dIn[0] = d;
    tIn[0] = t;
    for (int c = 1; c < l + 1 + 50; c++) begin
      @(negedge clk);
      loadV[0] = 1'b0;
      got = obsVec(0);
      exp = expVec(0, c, d, t);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_reset_pre cycle %0d got %b expected %b", c, got, exp);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obsVec(0) !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_clear outputs got %b expected 00000", obsVec(0));
    end
    @(negedge clk);
    rst = 1'b0;
    idleCheck(0, 140, "mid_reset_no_done");
    runBurst(0, rnd256(), rnd128(), 1'b0, -1, 1'b0, "mid_reset_fresh");
    idleCheck(0, 3, "mid_reset_idle");
  endtask

  task automatic test_y0();
    runBurst(1, rnd256(), rnd128(), 1'b0, -1, 1'b0, "y0_a");
    runBurst(1, {256{1'b1}}, rnd128(), 1'b0, 20, 1'b0, "y0_ones");
    idleCheck(1, 3, "y0_idle");
  endtask

  task automatic test_y200();
    runBurst(2, rnd256(), {128{1'b1}}, 1'b0, -1, 1'b0, "y200_a");
    runBurst(2, rnd256(), rnd128(), 1'b0, 150, 1'b1, "y200_b");
    idleCheck(2, 3, "y200_idle");
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) runBurst(3, rnd256(), rnd128(), 1'b1, -1, 1'b0, "lead0_held");
    idleCheck(3, 4, "lead0_idle");
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      dIn[k] = '0;
      tIn[k] = '0;
    end
    test_reset();
    test_basic();
    test_load_while_busy();
    test_mid_reset();
    test_y0();
    test_y200();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
